// File: rtl/fp_sqrt_pkg.sv
// Shared types and constants for the binary32 square-root front end.
package fp_sqrt_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN_INV} cls_t;

  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam logic [31:0] PINF   = 32'h7F800000;
  localparam int          BIAS   = 127;
  localparam int          MANT_W = 24;
endpackage

// File: rtl/fp_sqrt_classify.sv
// Combinational unpack: operand class, integer radicand and halved packed exponent.
module fp_sqrt_classify import fp_sqrt_pkg::*; #(
  parameter int ISQRT_W = 48,
  parameter int BIAS    = 127
) (
  input  logic [31:0]        in_float,
  output cls_t               cls,
  output logic [ISQRT_W-1:0] radicand,
  output logic [7:0]         exp_pack
);
  logic               s;
  logic [7:0]         e;
  logic [22:0]        f;
  logic [ISQRT_W-1:0] mant_x;
  logic signed [8:0]  e_unb;
  logic signed [8:0]  e_half;

  assign s = in_float[31];
  assign e = in_float[30:23];
  assign f = in_float[22:0];

  always_comb begin
    cls = CLS_NORMAL;
    if (e == 8'hFF && f != '0)  cls = CLS_NAN_INV;
    else if (s && e != 8'h00)   cls = CLS_NAN_INV;
    else if (e == 8'h00)        cls = CLS_ZERO;
    else if (e == 8'hFF)        cls = CLS_INF;
  end

  // odd unbiased exponent (E[0]==0) folds one extra factor of 2 into the radicand
  assign mant_x   = {{(ISQRT_W-MANT_W){1'b0}}, 1'b1, f};
  assign radicand = e[0] ? (mant_x << 23) : (mant_x << 24);

  // floor-halving keeps odd negative exponents consistent with the <<24 radicand
  assign e_unb    = $signed({1'b0, e}) - 9'sd127 + 9'(127 - BIAS);
  assign e_half   = e_unb >>> 1;
  assign exp_pack = 8'(e_half + 9'(BIAS));
endmodule

// File: rtl/fp_sqrt_ctrl.sv
// Binary32 sqrt sequencer: resolves specials locally, launches the integer unit
// for normals and packs its 24-bit root with the halved exponent.
module fp_sqrt_ctrl import fp_sqrt_pkg::*; #(
  parameter int ISQRT_W = 48,
  parameter int BIAS    = 127
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        in_float,
  output logic               busy,
  output logic               done,
  output logic [31:0]        out_float,
  output logic               invalid,
  output logic               isqrt_start,
  output logic [ISQRT_W-1:0] isqrt_num,
  input  logic               isqrt_ready,
  input  logic [ISQRT_W-1:0] isqrt_out
);
  state_t             state;
  cls_t               cls;
  logic [ISQRT_W-1:0] radicand;
  logic [7:0]         exp_pack;
  logic [7:0]         exp_q;
  logic               unused_root_hi;

  fp_sqrt_classify #(.ISQRT_W(ISQRT_W), .BIAS(BIAS)) u_cls (
    .in_float (in_float),
    .cls      (cls),
    .radicand (radicand),
    .exp_pack (exp_pack)
  );

  // root always lies in [2^23, 2^24): bit 23 is the implicit one
  assign unused_root_hi = ^isqrt_out[ISQRT_W-1:MANT_W-1];

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign isqrt_start = (state == LAUNCH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      out_float <= '0;
      invalid   <= 1'b0;
      isqrt_num <= '0;
      exp_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_q <= exp_pack;
          case (cls)
            CLS_NORMAL: begin
              isqrt_num <= radicand;
              state     <= LAUNCH;
            end
            CLS_ZERO: begin
              out_float <= {in_float[31], 31'b0};
              invalid   <= 1'b0;
              state     <= DONE;
            end
            CLS_INF: begin
              out_float <= PINF;
              invalid   <= 1'b0;
              state     <= DONE;
            end
            default: begin
              out_float <= QNAN;
              invalid   <= 1'b1;
              state     <= DONE;
            end
          endcase
        end
        LAUNCH: state <= SETTLE;
        // ready may still be high from the previous job here, so it is not looked at
        SETTLE: state <= WAIT;
        WAIT: if (isqrt_ready) begin
          out_float <= {1'b0, exp_q, isqrt_out[MANT_W-2:0]};
          invalid   <= 1'b0;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sqrt_ctrl.sv
// Directed bench for fp_sqrt_ctrl with a behavioural integer sqrt of
// programmable latency whose ready stays high until the next launch.
module tb_fp_sqrt_ctrl;
  localparam int W = 48;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  in_float;
  logic         busy;
  logic         done;
  logic [31:0]  out_float;
  logic         invalid;
  logic         isqrt_start;
  logic [W-1:0] isqrt_num;
  logic         isqrt_ready;
  logic [W-1:0] isqrt_out;

  int tests = 0;
  int fails = 0;
  int lat   = 2;
  int nlaunch = 0;
  int ndone   = 0;

  logic         start_d;
  int           cnt;
  logic [W-1:0] res;

  fp_sqrt_ctrl #(.ISQRT_W(W), .BIAS(127)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_float    (in_float),
    .busy        (busy),
    .done        (done),
    .out_float   (out_float),
    .invalid     (invalid),
    .isqrt_start (isqrt_start),
    .isqrt_num   (isqrt_num),
    .isqrt_ready (isqrt_ready),
    .isqrt_out   (isqrt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] int_sqrt(input logic [W-1:0] n);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int b = 24; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {16'd0, n}) r = t;
    end
    return r[W-1:0];
  endfunction

  // reset leaves a stale ready with a garbage root to catch early sampling
  always @(posedge clk) begin
    if (!rst) begin
      start_d     <= 1'b0;
      cnt         <= 0;
      isqrt_ready <= 1'b1;
      isqrt_out   <= 48'h7FFFFF;
    end else begin
      start_d <= isqrt_start;
      if (start_d) begin
        isqrt_ready <= 1'b0;
        cnt         <= lat;
        res         <= int_sqrt(isqrt_num);
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          isqrt_ready <= 1'b1;
          isqrt_out   <= res;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (isqrt_start) nlaunch++;
    if (done)        ndone++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request; inj_cyc > 0 pulses a stray start during that cycle.
  task automatic req(input string tag, input logic [31:0] f, input logic [31:0] exp_o,
                     input logic exp_inv, input bit special, input int exp_done_cyc,
                     input logic [W-1:0] exp_num, input int inj_cyc);
    int cyc;
    int n0;
    @(negedge clk);
    in_float = f;
    start    = 1'b1;
    n0       = nlaunch;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    if (special) begin
      chk({tag, " done@1"}, done, 1'b1);
      chk({tag, " no_launch"}, isqrt_start, 1'b0);
    end else begin
      chk({tag, " launch@1"}, isqrt_start, 1'b1);
      chk({tag, " num"}, isqrt_num, exp_num);
    end
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == inj_cyc) begin
        in_float = 32'h3E800000;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, done, 1'b1);
    if (!special) chk({tag, " done_cyc"}, cyc, exp_done_cyc);
    chk({tag, " out"}, out_float, exp_o);
    chk({tag, " inv"}, invalid, exp_inv);
    chk({tag, " launches"}, nlaunch - n0, special ? 0 : 1);
  endtask

  initial begin
    int d0;
    rst      = 1'b0;
    start    = 1'b0;
    in_float = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst launch", isqrt_start, 1'b0);
    chk("rst num", isqrt_num, 48'h0);
    chk("rst out", out_float, 32'h0);
    chk("rst inv", invalid, 1'b0);
    rst = 1'b1;

    lat = 2;
    req("sqrt4", 32'h40800000, 32'h40000000, 1'b0, 1'b0, 6, 48'h4000_0000_0000, 0);
    req("sqrt2", 32'h40000000, 32'h3FB504F3, 1'b0, 1'b0, 6, 48'h8000_0000_0000, 0);
    req("neg1",  32'hBF800000, 32'h7FC00000, 1'b1, 1'b1, 1, 48'h0, 0);
    repeat (2) @(negedge clk);
    chk("neg1 hold out", out_float, 32'h7FC00000);
    chk("neg1 hold inv", invalid, 1'b1);
    chk("neg1 hold busy", busy, 1'b0);

    // back-to-back specials: each start lands in the IDLE cycle after DONE
    req("pinf",  32'h7F800000, 32'h7F800000, 1'b0, 1'b1, 1, 48'h0, 0);
    req("nzero", 32'h80000000, 32'h80000000, 1'b0, 1'b1, 1, 48'h0, 0);
    req("denorm",32'h00000001, 32'h00000000, 1'b0, 1'b1, 1, 48'h0, 0);
    req("nan",   32'h7FC00001, 32'h7FC00000, 1'b1, 1'b1, 1, 48'h0, 0);
    req("ninf",  32'hFF800000, 32'h7FC00000, 1'b1, 1'b1, 1, 48'h0, 0);

    lat = 20;
    req("ignore", 32'h40800000, 32'h40000000, 1'b0, 1'b0, 24, 48'h4000_0000_0000, 5);
    @(negedge clk);
    chk("ignore idle", busy, 1'b0);
    lat = 2;
    req("q", 32'h3E800000, 32'h3F000000, 1'b0, 1'b0, 6, 48'h4000_0000_0000, 0);

    // reset during WAIT abandons the job
    lat = 20;
    @(negedge clk);
    in_float = 32'h40800000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid busy", busy, 1'b1);
    d0  = ndone;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort busy", busy, 1'b0);
    chk("abort out", out_float, 32'h0);
    chk("abort inv", invalid, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort num", isqrt_num, 48'h0);
    repeat (25) @(negedge clk);
    chk("abort no_done", ndone - d0, 0);
    lat = 2;
    req("post_rst", 32'h40800000, 32'h40000000, 1'b0, 1'b0, 6, 48'h4000_0000_0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
